inpdt_acc: RTL and testbench

INPDT_ACC -- requirements
Module: inpdt_acc

---
 rtl/inpdt_acc_pkg.sv | 25 ++
 rtl/inpdt_mac.sv | 26 ++
 rtl/inpdt_acc.sv | 108 ++++++++++
 tb/tb_inpdt_acc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inpdt_acc_pkg.sv
// Shared quantization package: inner-product FSM encoding, default zero points
// and the LSTM sequencing states that use the inner-product engine.
package inpdt_acc_pkg;

    localparam logic [7:0] ZERO_DATA_DEFAULT = 8'd128;
    localparam logic [7:0] ZERO_W_DEFAULT    = 8'd128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } inpdt_state_e;

    typedef enum logic [2:0] {
        LSTM_IDLE   = 3'd0,
        LSTM_GATE_I = 3'd1,
        LSTM_GATE_F = 3'd2,
        LSTM_GATE_G = 3'd3,
        LSTM_GATE_O = 3'd4,
        LSTM_CELL   = 3'd5,
        LSTM_HIDDEN = 3'd6
    } lstm_state_e;

endpackage

// File: rtl/inpdt_mac.sv
// Zero-point-corrected signed multiply of one x/w pair (purely combinational).
module inpdt_mac
    import inpdt_acc_pkg::*;
#(
    parameter logic [7:0] ZERO_DATA = ZERO_DATA_DEFAULT,
    parameter logic [7:0] ZERO_W    = ZERO_W_DEFAULT
) (
    input  logic [7:0]         x_data,
    input  logic [7:0]         w_data,
    output logic signed [16:0] product
);

    logic signed [8:0]  x_off;
    logic signed [8:0]  w_off;
    logic signed [16:0] x_ext;
    logic signed [16:0] w_ext;

    assign x_off = $signed({1'b0, x_data}) - $signed({1'b0, ZERO_DATA});
    assign w_off = $signed({1'b0, w_data}) - $signed({1'b0, ZERO_W});

    // |x_off|,|w_off| <= 255 so the product always fits 17 signed bits.
    assign x_ext   = 17'(x_off);
    assign w_ext   = 17'(w_off);
    assign product = x_ext * w_ext;

endmodule

// File: rtl/inpdt_acc.sv
// Quantized inner-product accumulator: streams VEC_LEN x/w pairs, sums products.
// Optional INPDT_ACC_ABORT_EN adds an abort input that returns the block to IDLE.
module inpdt_acc
    import inpdt_acc_pkg::*;
#(
    parameter int         VEC_LEN   = 64,
    parameter logic [7:0] ZERO_DATA = ZERO_DATA_DEFAULT,
    parameter logic [7:0] ZERO_W    = ZERO_W_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  bias_in,
`ifdef INPDT_ACC_ABORT_EN
    input  logic        abort,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  x_data,
    input  logic [7:0]  w_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inpdt_R_reg,
    output logic [7:0]  bias_buffer,
    output logic        busy
);

    localparam int               CNT_W    = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VEC_LEN);

    inpdt_state_e       state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [31:0]        acc_reg;
    logic signed [16:0] prod_reg;
    logic               prod_valid_reg;
    logic [7:0]         bias_reg;
    logic signed [16:0] mac_product;
    logic               accept;
    logic               abort_hit;

    inpdt_mac #(
        .ZERO_DATA (ZERO_DATA),
        .ZERO_W    (ZERO_W)
    ) u_mac (
        .x_data  (x_data),
        .w_data  (w_data),
        .product (mac_product)
    );

`ifdef INPDT_ACC_ABORT_EN
    assign abort_hit = abort && (state_reg != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign in_ready    = (state_reg == ST_ACCUM) && (cnt_reg < CNT_FULL);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_reg == ST_DONE);
    assign busy        = (state_reg != ST_IDLE);
    assign inpdt_R_reg = acc_reg;
    assign bias_buffer = bias_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_ACCUM;
            ST_ACCUM: if (accept && cnt_reg == CNT_LAST) state_next = ST_DRAIN;
            // Leave DRAIN only once the last registered product has been added.
            ST_DRAIN: if (!prod_valid_reg) state_next = ST_DONE;
            ST_DONE:  if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (abort_hit) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            acc_reg        <= '0;
            prod_reg       <= '0;
            prod_valid_reg <= 1'b0;
            bias_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (abort_hit) begin
                cnt_reg        <= '0;
                acc_reg        <= '0;
                prod_valid_reg <= 1'b0;
            end else begin
                prod_valid_reg <= accept;
                if (accept) begin
                    prod_reg <= mac_product;
                    cnt_reg  <= cnt_reg + 1'b1;
                end
                if (state_reg == ST_IDLE && start) begin
                    acc_reg  <= '0;
                    cnt_reg  <= '0;
                    bias_reg <= bias_in;
                end else if (prod_valid_reg) begin
                    acc_reg <= acc_reg + {{15{prod_reg[16]}}, prod_reg};
                end
            end
        end
    end

endmodule

// File: tb/tb_inpdt_acc.sv
// Self-checking bench for inpdt_acc: directed and random products on a 4-element
// and a 64-element instance, checked against an arithmetic reference model.
module tb_inpdt_acc;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        start_s     [2];
    logic [7:0]  bias_in_s   [2];
    logic        in_valid_s  [2];
    logic        in_ready_s  [2];
    logic [7:0]  x_s         [2];
    logic [7:0]  w_s         [2];
    logic        out_valid_s [2];
    logic        out_ready_s [2];
    logic [31:0] r_s         [2];
    logic [7:0]  bb_s        [2];
    logic        busy_s      [2];
`ifdef INPDT_ACC_ABORT_EN
    logic        abort_s     [2];
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] xv [64];
    logic [7:0] wv [64];
    int vlen [2] = '{4, 64};

    inpdt_acc #(.VEC_LEN(4)) dut4 (
        .clk(clk), .resetn(resetn), .start(start_s[0]), .bias_in(bias_in_s[0]),
`ifdef INPDT_ACC_ABORT_EN
        .abort(abort_s[0]),
`endif
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .x_data(x_s[0]), .w_data(w_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .inpdt_R_reg(r_s[0]),
        .bias_buffer(bb_s[0]), .busy(busy_s[0])
    );

    inpdt_acc #(.VEC_LEN(64)) dut64 (
        .clk(clk), .resetn(resetn), .start(start_s[1]), .bias_in(bias_in_s[1]),
`ifdef INPDT_ACC_ABORT_EN
        .abort(abort_s[1]),
`endif
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .x_data(x_s[1]), .w_data(w_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .inpdt_R_reg(r_s[1]),
        .bias_buffer(bb_s[1]), .busy(busy_s[1])
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Sum of zero-point-corrected products, wrapped to 32 bits.
    function automatic logic [31:0] model(input int n);
        int s = 0;
        for (int k = 0; k < n; k++)
            s += (int'(xv[k]) - 128) * (int'(wv[k]) - 128);
        return 32'(s);
    endfunction

    task automatic start_prod(input int id, input logic [7:0] b);
        @(negedge clk);
        start_s[id]   = 1'b1;
        bias_in_s[id] = b;
        @(negedge clk);
        start_s[id] = 1'b0;
        chk1("busy_after_start", busy_s[id], 1'b1);
        chk1("in_ready_accum", in_ready_s[id], 1'b1);
        chk32("acc_cleared", r_s[id], 32'd0);
        chk32("bias_captured", 32'(bb_s[id]), 32'(b));
    endtask

    task automatic feed(input int id, input int n, input int gap);
        int waitc;
        for (int k = 0; k < n; k++) begin
            in_valid_s[id] = 1'b1;
            x_s[id] = xv[k];
            w_s[id] = wv[k];
            waitc = 0;
            while (in_ready_s[id] !== 1'b1 && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            if (waitc != 0) chk1("in_ready_wait", in_ready_s[id], 1'b1);
            @(negedge clk);
            in_valid_s[id] = 1'b0;
            if (k < n - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int id, output int lat);
        lat = 0;
        while (out_valid_s[id] !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_prod(input int id, input int hold, input logic [31:0] er, input logic [7:0] eb);
        for (int i = 0; i < hold; i++) begin
            out_ready_s[id] = 1'b0;
            start_s[id]     = (i % 3 == 0);
            bias_in_s[id]   = 8'hEE;
            @(negedge clk);
            chk1("hold_out_valid", out_valid_s[id], 1'b1);
            chk32("hold_result", r_s[id], er);
            chk32("hold_bias", 32'(bb_s[id]), 32'(eb));
        end
        // Start coincident with the output handshake must be ignored.
        out_ready_s[id] = 1'b1;
        start_s[id]     = 1'b1;
        bias_in_s[id]   = 8'hEE;
        @(negedge clk);
        out_ready_s[id] = 1'b0;
        start_s[id]     = 1'b0;
        chk1("valid_dropped", out_valid_s[id], 1'b0);
        chk1("idle_after_hs", busy_s[id], 1'b0);
        chk32("bias_after_hs", 32'(bb_s[id]), 32'(eb));
    endtask

    task automatic run_full(input int id, input int gap, input int hold, input logic [7:0] b);
        logic [31:0] er;
        int lat;
        er = model(vlen[id]);
        start_prod(id, b);
        feed(id, vlen[id], gap);
        chk1("in_ready_drain", in_ready_s[id], 1'b0);
        wait_valid(id, lat);
        chk32("latency", 32'(lat), 32'd2);
        chk32("result", r_s[id], er);
        chk32("bias", 32'(bb_s[id]), 32'(b));
        $display("product dut=%0d len=%0d gap=%0d bias=%0d result=%0d expected=%0d latency=%0d",
                 id, vlen[id], gap, b, $signed(r_s[id]), $signed(er), lat);
        finish_prod(id, hold, er, b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; bias_in_s[i] = 8'd0; in_valid_s[i] = 1'b0;
            x_s[i] = 8'd0; w_s[i] = 8'd0; out_ready_s[i] = 1'b0;
`ifdef INPDT_ACC_ABORT_EN
            abort_s[i] = 1'b0;
`endif
        end
        #1;
        chk1("rst_busy", busy_s[0], 1'b0);
        chk1("rst_out_valid", out_valid_s[0], 1'b0);
        chk1("rst_in_ready", in_ready_s[0], 1'b0);
        chk32("rst_result", r_s[0], 32'd0);
        chk32("rst_bias", 32'(bb_s[0]), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Back-to-back 129/130 pairs.
        for (int k = 0; k < 4; k++) begin xv[k] = 8'd129; wv[k] = 8'd130; end
        run_full(0, 0, 0, 8'd10);

        // Mixed-sign pairs with 3-cycle gaps.
        xv[0] = 8'd129; wv[0] = 8'd130;
        xv[1] = 8'd127; wv[1] = 8'd130;
        xv[2] = 8'd128; wv[2] = 8'd0;
        xv[3] = 8'd200; wv[3] = 8'd56;
        run_full(0, 3, 0, 8'd20);

        // Extremes on the 64-element instance.
        for (int k = 0; k < 64; k++) begin xv[k] = 8'd0; wv[k] = 8'd0; end
        run_full(1, 0, 0, 8'd1);
        for (int k = 0; k < 64; k++) begin xv[k] = 8'd255; wv[k] = 8'd0; end
        run_full(1, 0, 0, 8'd2);

        // Backpressure in DONE with start pulses that must be ignored.
        for (int k = 0; k < 4; k++) begin xv[k] = 8'(k * 50); wv[k] = 8'(255 - k * 40); end
        run_full(0, 1, 10, 8'd99);

        // Reset after two of four pairs discards the partial sum.
        for (int k = 0; k < 4; k++) begin xv[k] = 8'd129; wv[k] = 8'd129; end
        start_prod(0, 8'd33);
        feed(0, 2, 0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk1("midrst_busy", busy_s[0], 1'b0);
        chk1("midrst_in_ready", in_ready_s[0], 1'b0);
        chk32("midrst_result", r_s[0], 32'd0);
        chk32("midrst_bias", 32'(bb_s[0]), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        wait_valid(0, lat);
        chk1("no_valid_after_rst", out_valid_s[0], 1'b0);
        run_full(0, 0, 0, 8'd7);

`ifdef INPDT_ACC_ABORT_EN
        start_prod(0, 8'd5);
        feed(0, 3, 1);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        chk1("abort_busy", busy_s[0], 1'b0);
        chk1("abort_out_valid", out_valid_s[0], 1'b0);
        chk32("abort_acc", r_s[0], 32'd0);
        wait_valid(0, lat);
        chk1("no_valid_after_abort", out_valid_s[0], 1'b0);
        for (int k = 0; k < 4; k++) begin xv[k] = 8'd140; wv[k] = 8'd100; end
        run_full(0, 0, 0, 8'd6);
`endif

        // Random products on both instances.
        for (int t = 0; t < 8; t++) begin
            int id;
            id = (t % 4 == 3) ? 1 : 0;
            for (int k = 0; k < 64; k++) begin
                xv[k] = 8'($urandom_range(0, 255));
                wv[k] = 8'($urandom_range(0, 255));
            end
            run_full(id, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                     8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
